// File: rtl/cbus_arbiter_pkg.sv
// Shared CBus channel types, their idle/zero values and the arbiter state encoding.
package cbus_arbiter_pkg;

    localparam int CBUS_ADDR_W = 32;
    localparam int CBUS_DATA_W = 32;
    localparam int CBUS_LEN_W  = 8;

    typedef struct packed {
        logic                   valid;
        logic                   is_write;
        logic [1:0]             size;
        logic [CBUS_ADDR_W-1:0] addr;
        logic [3:0]             strobe;
        logic [CBUS_DATA_W-1:0] data;
        logic [CBUS_LEN_W-1:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic                   ready;
        logic                   last;
        logic [CBUS_DATA_W-1:0] data;
    } cbus_resp_t;

    localparam cbus_req_t  CBUS_REQ_ZERO  = '0;
    localparam cbus_resp_t CBUS_RESP_ZERO = '0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational winner selection: first valid index scanning upward from a start point,
// where the start is rr_ptr in round-robin mode and 0 in fixed-priority mode.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    input  logic               round_robin,
    output logic               found,
    output logic [IDX_W-1:0]   winner
);

    int               start;
    logic [IDX_W-1:0] cur;

    // Scan from the far end down so the candidate closest to start is written last.
    always_comb begin
        found  = |valid;
        winner = '0;
        cur    = '0;
        start  = round_robin ? int'(rr_ptr) : 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cur = IDX_W'((start + k) % NUM_REQ);
            if (valid[cur]) begin
                winner = cur;
            end
        end
    end

endmodule

// File: rtl/cbus_arbiter.sv
// N-way CBus arbiter: grants one upstream channel for a whole burst, with one idle
// cycle between bursts, under fixed or round-robin priority.
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter bit ROUND_ROBIN = 1'b1,
    parameter int IDX_W       = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  cbus_req_t        ireqs  [NUM_REQ],
    output cbus_resp_t       iresps [NUM_REQ],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic             busy,
    output logic [IDX_W-1:0] grant_idx
);

    arb_state_t        state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [NUM_REQ-1:0] valid_vec;
    logic              found;
    logic [IDX_W-1:0]  winner;
    logic              granted_valid;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    always_comb begin
        valid_vec     = '0;
        granted_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            valid_vec[i] = ireqs[i].valid;
            if (grant_idx == IDX_W'(i)) begin
                granted_valid = ireqs[i].valid;
            end
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .valid       (valid_vec),
        .rr_ptr      (rr_ptr),
        .round_robin (ROUND_ROBIN),
        .found       (found),
        .winner      (winner)
    );

    // Arbitration only in IDLE; completion always falls back to IDLE, giving the bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            grant_idx <= '0;
            rr_ptr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= BUSY;
                        busy      <= 1'b1;
                        grant_idx <= winner;
                    end
                end
                BUSY: begin
                    if (!granted_valid) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (oresp.ready && oresp.last) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= next_idx(grant_idx);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Passthrough is gated by the registered state, so ireqs never reach oreq in IDLE.
    always_comb begin
        oreq = CBUS_REQ_ZERO;
        for (int i = 0; i < NUM_REQ; i++) begin
            iresps[i] = CBUS_RESP_ZERO;
            if (state == BUSY && grant_idx == IDX_W'(i)) begin
                oreq      = ireqs[i];
                iresps[i] = oresp;
            end
        end
    end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter (2-way and 3-way, both policies) and rr_pick.
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    cbus_req_t  req2 [2];
    cbus_req_t  req3 [3];
    cbus_resp_t resp2 [2];
    cbus_resp_t resp3 [3];
    cbus_resp_t resp3f [3];
    cbus_req_t  oreq2, oreq3, oreq3f;
    cbus_resp_t oresp;
    logic       busy2, busy3, busy3f;
    logic [0:0] gidx2;
    logic [1:0] gidx3, gidx3f;

    logic [2:0] pv;
    logic [1:0] pp;
    logic       pm;
    logic       pf;
    logic [1:0] pw;

    cbus_arbiter #(.NUM_REQ(2), .ROUND_ROBIN(1'b1)) dut2 (
        .clk(clk), .reset(reset), .ireqs(req2), .iresps(resp2),
        .oreq(oreq2), .oresp(oresp), .busy(busy2), .grant_idx(gidx2)
    );

    cbus_arbiter #(.NUM_REQ(3), .ROUND_ROBIN(1'b1)) dut3 (
        .clk(clk), .reset(reset), .ireqs(req3), .iresps(resp3),
        .oreq(oreq3), .oresp(oresp), .busy(busy3), .grant_idx(gidx3)
    );

    cbus_arbiter #(.NUM_REQ(3), .ROUND_ROBIN(1'b0)) dut3f (
        .clk(clk), .reset(reset), .ireqs(req3), .iresps(resp3f),
        .oreq(oreq3f), .oresp(oresp), .busy(busy3f), .grant_idx(gidx3f)
    );

    rr_pick #(.NUM_REQ(3), .IDX_W(2)) u_pick (
        .valid(pv), .rr_ptr(pp), .round_robin(pm), .found(pf), .winner(pw)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] v;
        logic       rdy;
        logic       lst;
        logic       busy;
        logic [0:0] g;
        logic       ov;
    } vec_t;

    vec_t tab[$];

    task automatic add(input logic rst, input logic [1:0] v, input logic rdy, input logic lst,
                       input logic b, input logic g, input logic ov);
        vec_t e;
        e.rst = rst; e.v = v; e.rdy = rdy; e.lst = lst; e.busy = b; e.g = g; e.ov = ov;
        tab.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set3(input logic [2:0] v, input logic rdy, input logic lst);
        for (int i = 0; i < 3; i++) req3[i].valid = v[i];
        oresp.ready = rdy;
        oresp.last  = lst;
    endtask

    initial begin
        int exp_rr [5];
        logic       sel;
        logic       mf;
        logic [1:0] mw;
        int         idx;
        exp_rr = '{0, 1, 2, 0, 1};

        //      rst   v      rdy   lst   busy  g     ov
        add(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // 0 idle after reset
        add(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // 1 ch1 valid, arbitrating
        add(1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);  // 2 granted ch1
        add(1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);  // 3 last beat
        add(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // 4 back to idle
        add(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // 5 ch0 request
        add(1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);  // 6 beat 0
        add(1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);  // 7 beat 1
        add(1'b0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);  // 8 beat 2, ch1 asks
        add(1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);  // 9 beat 3 last
        add(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // 10 bubble
        add(1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);  // 11 ch1 granted
        add(1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);  // 12 ch1 last
        add(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // 13
        add(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // 14
        add(1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);  // 15 ch0 single beat, ptr->1
        add(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // 16 both valid
        add(1'b0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);  // 17 ch1 wins, beat 0
        add(1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);  // 18 reset at beat 1
        add(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  // 19 all zero after reset
        add(1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);  // 20 ptr restarted at 0
        add(1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);  // 21
        add(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // 22

        reset = 1'b1;
        oresp = CBUS_RESP_ZERO;
        oresp.data = 32'hCAFE_0000;
        for (int i = 0; i < 2; i++) begin
            req2[i] = CBUS_REQ_ZERO;
            req2[i].addr = 32'h1000 + 32'(i * 16);
            req2[i].len  = 8'd3;
        end
        for (int i = 0; i < 3; i++) begin
            req3[i] = CBUS_REQ_ZERO;
            req3[i].addr = 32'h2000 + 32'(i * 16);
        end
        next_cycle();
        next_cycle();
        reset = 1'b0;

        chk("reset busy2", 32'(busy2), 32'd0);
        chk("reset gidx2", 32'(gidx2), 32'd0);
        chk("reset oreq2", 32'(oreq2.valid), 32'd0);
        chk("reset busy3", 32'(busy3), 32'd0);
        chk("reset gidx3", 32'(gidx3), 32'd0);

        foreach (tab[r]) begin
            reset          = tab[r].rst;
            req2[0].valid  = tab[r].v[0];
            req2[1].valid  = tab[r].v[1];
            oresp.ready    = tab[r].rdy;
            oresp.last     = tab[r].lst;
            #3;
            chk($sformatf("row%0d busy", r), 32'(busy2), 32'(tab[r].busy));
            chk($sformatf("row%0d oreq.valid", r), 32'(oreq2.valid), 32'(tab[r].ov));
            if (tab[r].busy) begin
                chk($sformatf("row%0d grant_idx", r), 32'(gidx2), 32'(tab[r].g));
                chk($sformatf("row%0d oreq.addr", r), oreq2.addr, 32'h1000 + 32'(tab[r].g) * 16);
            end
            for (int i = 0; i < 2; i++) begin
                sel = tab[r].busy && (32'(tab[r].g) == 32'(i));
                chk($sformatf("row%0d iresps%0d.ready", r, i), 32'(resp2[i].ready),
                    32'(sel ? tab[r].rdy : 1'b0));
                chk($sformatf("row%0d iresps%0d.last", r, i), 32'(resp2[i].last),
                    32'(sel ? tab[r].lst : 1'b0));
                chk($sformatf("row%0d iresps%0d.data", r, i), resp2[i].data,
                    sel ? 32'hCAFE_0000 : 32'h0);
            end
            next_cycle();
        end
        reset = 1'b0;
        req2[0].valid = 1'b0;
        req2[1].valid = 1'b0;

        // Round-robin fairness vs fixed priority, all channels continuously valid.
        for (int b = 0; b < 5; b++) begin
            set3(3'b111, 1'b0, 1'b0);
            #3;
            chk($sformatf("rr%0d bubble busy3", b), 32'(busy3), 32'd0);
            chk($sformatf("rr%0d bubble busy3f", b), 32'(busy3f), 32'd0);
            next_cycle();
            set3(3'b111, 1'b1, 1'b1);
            #3;
            chk($sformatf("rr%0d busy3", b), 32'(busy3), 32'd1);
            chk($sformatf("rr%0d grant rr", b), 32'(gidx3), 32'(exp_rr[b]));
            chk($sformatf("rr%0d grant fixed", b), 32'(gidx3f), 32'd0);
            chk($sformatf("rr%0d oreq.addr", b), oreq3.addr, 32'h2000 + 32'(exp_rr[b] * 16));
            next_cycle();
        end

        // Abort: channel 2 granted, drops valid before last.
        set3(3'b111, 1'b0, 1'b0);
        #3;
        chk("abort idle before", 32'(busy3), 32'd0);
        next_cycle();
        #3;
        chk("abort grant2 busy", 32'(busy3), 32'd1);
        chk("abort grant2 idx", 32'(gidx3), 32'd2);
        chk("abort oreq.valid", 32'(oreq3.valid), 32'd1);
        next_cycle();
        set3(3'b011, 1'b0, 1'b0);
        #3;
        chk("abort passthrough valid", 32'(oreq3.valid), 32'd0);
        next_cycle();
        set3(3'b111, 1'b0, 1'b0);
        #3;
        chk("abort busy after", 32'(busy3), 32'd0);
        next_cycle();
        set3(3'b111, 1'b1, 1'b1);
        #3;
        chk("abort regrant busy", 32'(busy3), 32'd1);
        chk("abort regrant idx", 32'(gidx3), 32'd2);
        chk("abort regrant last2", 32'(resp3[2].last), 32'd1);
        chk("abort ch0 not ready", 32'(resp3[0].ready), 32'd0);
        next_cycle();
        set3(3'b000, 1'b0, 1'b0);

        // Exhaustive rr_pick check against a first-hit scan model.
        for (int m = 0; m < 2; m++) begin
            for (int p = 0; p < 3; p++) begin
                for (int v = 0; v < 8; v++) begin
                    pm = m[0];
                    pp = 2'(p);
                    pv = 3'(v);
                    #1;
                    mf = 1'b0;
                    mw = 2'd0;
                    for (int k = 0; k < 3; k++) begin
                        idx = ((m != 0 ? p : 0) + k) % 3;
                        if (!mf && pv[idx[1:0]]) begin
                            mf = 1'b1;
                            mw = idx[1:0];
                        end
                    end
                    chk($sformatf("pick m%0d p%0d v%0d found", m, p, v), 32'(pf), 32'(mf));
                    if (mf) begin
                        chk($sformatf("pick m%0d p%0d v%0d winner", m, p, v), 32'(pw), 32'(mw));
                    end
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
